// File: rtl/rc_pwm_pkg.sv
// Shared definitions for the RC PWM width-capture block and the mode-switch logic.
// Tick constants are in width ticks unless stated otherwise.
package rc_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  localparam int TICK_DIV         = 500;   // clk cycles per tick (50 MHz -> 10 us)
  localparam int MIN_TICKS        = 50;
  localparam int MAX_TICKS        = 250;
  localparam int TIMEOUT_TICKS    = 5000;
  localparam int SWITCH_THRESHOLD = 150;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus an edge flop; rise/fall share the same latency.
// Edges are suppressed until the chain holds post-reset samples, so a line that is
// already high when reset releases never looks like a fresh rising edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] fill;
  logic       filled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign filled = (fill == 2'd3);
  assign level  = s2;
  assign rise   = filled &  s2 & ~s3;
  assign fall   = filled & ~s2 &  s3;

endmodule

// File: rtl/rc_pwm_width_capture.sv
// Measures the high time of one RC PWM channel in ticks, rejects glitches and
// over-long pulses, and drops the width to 0 when no accepted pulse arrives in time.
module rc_pwm_width_capture #(
  parameter int TICK_DIV      = rc_pwm_pkg::TICK_DIV,
  parameter int MIN_TICKS     = rc_pwm_pkg::MIN_TICKS,
  parameter int MAX_TICKS     = rc_pwm_pkg::MAX_TICKS,
  parameter int TIMEOUT_TICKS = rc_pwm_pkg::TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] pulse_width,
  output logic       width_valid,
  output logic       signal_ok,
  output logic       glitch,
  output logic [1:0] fsm_state
);

  import rc_pwm_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          level;
  logic          rise;
  logic          fall;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    count;
  logic [8:0]    count_eff;
  logic [15:0]   to_cnt;
  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          reject;

  sync_edge_detect u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (rise) presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           count <= 8'd0;
    else if (rise)                        count <= 8'd0;
    else if (state == MEASURE && tick)    count <= count + 8'd1;
  end

  // A tick landing in the same cycle as the fall is a completed tick, so it counts.
  assign count_eff = {1'b0, count} + {8'd0, tick};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (fall) begin
          state_next = IDLE;
          if (count_eff < 9'(MIN_TICKS))       reject = 1'b1;
          else if (count_eff <= 9'(MAX_TICKS)) accept = 1'b1;
          else                                 reject = 1'b1;
        end else if (count_eff == 9'(MAX_TICKS + 1)) begin
          reject     = 1'b1;
          state_next = STUCK;
        end
      end
      STUCK: begin
        if (!level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

  // Acceptance takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_width <= 8'd0;
      width_valid <= 1'b0;
      signal_ok   <= 1'b0;
      glitch      <= 1'b0;
      to_cnt      <= 16'd0;
    end else begin
      width_valid <= 1'b0;
      glitch      <= reject;
      if (accept) begin
        pulse_width <= count_eff[7:0];
        width_valid <= 1'b1;
        signal_ok   <= 1'b1;
        to_cnt      <= 16'd0;
      end else if (tick && to_cnt != 16'(TIMEOUT_TICKS)) begin
        to_cnt <= to_cnt + 16'd1;
        if (to_cnt == 16'(TIMEOUT_TICKS - 1)) begin
          signal_ok   <= 1'b0;
          pulse_width <= 8'd0;
        end
      end
    end
  end

endmodule
